// File: rtl/qeciphy_pkg.sv
// qeciphy_pkg: shared types, constants and the CRC16-IBM3740 64-bit step used by the TX framer
package qeciphy_pkg;
  localparam logic [47:0] CRC_WORD_MARKER = 48'hC3C3_5A5A_A5A5;
  localparam int CRC_LATENCY = 2;
  typedef enum logic {ACCEPT, BUBBLE} framer_state_t;
  typedef struct packed {
    logic [63:0] data;
    logic        vld;
    logic        last;
  } stage_t;
  function automatic logic [15:0] crc16_step64(input logic [15:0] crc, input logic [63:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 63; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ data[i]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction
endpackage

// File: rtl/qeciphy_crc16_ibm3740.sv
// qeciphy_crc16_ibm3740: running CRC16 (poly 0x1021, init 0xFFFF) over 64-bit words, fixed 2-cycle latency
//   clk_i, rst_n_i       clock, async active-low reset (re-seeds to 0xFFFF)
//   tdata_i, tvalid_i    word to fold into the running CRC
//   crc_o, crc_valid_o   running CRC covering a word, two cycles after that word
module qeciphy_crc16_ibm3740
  import qeciphy_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] tdata_i,
  input  logic        tvalid_i,
  output logic [15:0] crc_o,
  output logic        crc_valid_o
);
  logic [15:0] run_q, run_d, crc_q, crc_d;
  logic [CRC_LATENCY-1:0] vld_q, vld_d;
  always_comb begin
    run_d = tvalid_i ? crc16_step64(run_q, tdata_i) : run_q;
    crc_d = run_q;
    vld_d = {vld_q[CRC_LATENCY-2:0], tvalid_i};
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q <= 16'hFFFF;
      crc_q <= 16'hFFFF;
      vld_q <= '0;
    end else begin
      run_q <= run_d;
      crc_q <= crc_d;
      vld_q <= vld_d;
    end
  end
  assign crc_o = crc_q;
  assign crc_valid_o = vld_q[CRC_LATENCY-1];
endmodule

// File: rtl/qeciphy_tx_crc_framer.sv
// qeciphy_tx_crc_framer: appends a {marker, running CRC16} word after every FRAME_WORDS data words
//   clk_i, rst_n_i                   clock, async active-low reset
//   s_tdata_i, s_tvalid_i, s_tready_o  user stream in (ready drops for one bubble after each frame)
//   m_tdata_o, m_tvalid_o, m_tlast_o   framed stream out, data delayed 2 cycles, tlast on the CRC word
//   crc_err_o                        sticky: engine valid disagrees with the expected 2-cycle timing
//   frame_cnt_o                      CRC words emitted
module qeciphy_tx_crc_framer
  import qeciphy_pkg::*;
#(
  parameter int          FRAME_WORDS = 8,
  parameter logic [47:0] CRC_MARKER  = CRC_WORD_MARKER
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [63:0] s_tdata_i,
  input  logic        s_tvalid_i,
  output logic        s_tready_o,
  output logic [63:0] m_tdata_o,
  output logic        m_tvalid_o,
  output logic        m_tlast_o,
  output logic        crc_err_o,
  output logic [31:0] frame_cnt_o
);
  localparam int CW = $clog2(FRAME_WORDS);
  framer_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rdy_q, rdy_d, tlast_q, tlast_d, err_q, err_d;
  logic [31:0] frames_q, frames_d;
  stage_t d1_q, d1_d, out_q, out_d;
  logic transfer, last_word, crc_ins, crc_valid;
  logic [15:0] crc;
  qeciphy_crc16_ibm3740 u_crc (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .tdata_i    (s_tdata_i),
    .tvalid_i   (transfer),
    .crc_o      (crc),
    .crc_valid_o(crc_valid)
  );
  // The CRC word rides in the empty slot left by the bubble, so it directly follows the last data word.
  always_comb begin
    transfer = s_tvalid_i & rdy_q;
    last_word = cnt_q == CW'(FRAME_WORDS - 1);
    cnt_d = transfer ? (last_word ? '0 : cnt_q + 1'b1) : cnt_q;
    state_d = (state_q == ACCEPT) ? ((transfer && last_word) ? BUBBLE : ACCEPT) : ACCEPT;
    rdy_d = state_d == ACCEPT;
    d1_d = '{data: s_tdata_i, vld: transfer, last: transfer & last_word};
    crc_ins = out_q.vld & out_q.last;
    out_d = d1_q.vld ? d1_q : (crc_ins ? stage_t'({CRC_MARKER, crc, 2'b10}) : '0);
    tlast_d = ~d1_q.vld & crc_ins;
    frames_d = frames_q + 32'(crc_ins);
    err_d = err_q | (crc_valid != (out_q.vld & ~tlast_q));
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ACCEPT;
      cnt_q <= '0;
      rdy_q <= 1'b0;
      d1_q <= '0;
      out_q <= '0;
      tlast_q <= 1'b0;
      frames_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      d1_q <= d1_d;
      out_q <= out_d;
      tlast_q <= tlast_d;
      frames_q <= frames_d;
      err_q <= err_d;
    end
  end
  assign s_tready_o = rdy_q;
  assign m_tdata_o = out_q.data;
  assign m_tvalid_o = out_q.vld;
  assign m_tlast_o = tlast_q;
  assign crc_err_o = err_q;
  assign frame_cnt_o = frames_q;
endmodule

// File: tb/tb_qeciphy_tx_crc_framer.sv
// tb_qeciphy_tx_crc_framer: randomized and directed checks of the TX CRC framer against a cycle timeline model
module tb_qeciphy_tx_crc_framer;
  localparam int FW = 4;
  localparam logic [47:0] MARK = 48'hC3C3_5A5A_A5A5;
  logic clk = 0, rst_n = 0, s_tvalid = 0;
  logic [63:0] s_tdata = '0;
  logic s_tready, m_tvalid, m_tlast, crc_err;
  logic [63:0] m_tdata;
  logic [31:0] frame_cnt;
  int cyc = 0, compared = 0, fails = 0;
  bit tr_v[4096], tr_l[4096], tr_r[4096], tr_e[4096];
  logic [63:0] tr_d[4096];
  logic [31:0] tr_f[4096];
  bit exp_v[4096], exp_l[4096];
  logic [63:0] exp_d[4096];
  logic [15:0] mcrc, crc_s2;
  int mcnt, mframes;

  qeciphy_tx_crc_framer #(.FRAME_WORDS(FW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
    .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tlast_o(m_tlast), .crc_err_o(crc_err), .frame_cnt_o(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    tr_v[cyc] = m_tvalid;
    tr_l[cyc] = m_tlast;
    tr_d[cyc] = m_tdata;
    tr_r[cyc] = s_tready;
    tr_e[cyc] = crc_err;
    tr_f[cyc] = frame_cnt;
  end

  // Reference CRC: message bits MSB first through the 0x1021 generator.
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [63:0] w);
    int r;
    r = int'(c);
    for (int b = 63; b >= 0; b--) r = ((((r >> 15) & 1) ^ int'(w[b])) != 0) ? (((r << 1) ^ 32'h1021) & 32'hFFFF) : ((r << 1) & 32'hFFFF);
    return r[15:0];
  endfunction

  task automatic model_reset();
    mcrc = 16'hFFFF;
    mcnt = 0;
    mframes = 0;
  endtask

  task automatic model_word(input int c, input logic [63:0] w);
    exp_v[c+2] = 1;
    exp_l[c+2] = 0;
    exp_d[c+2] = w;
    mcrc = ref_crc(mcrc, w);
    mcnt++;
    if (mcnt == FW) begin
      exp_v[c+3] = 1;
      exp_l[c+3] = 1;
      exp_d[c+3] = {MARK, mcrc};
      mcnt = 0;
      mframes++;
    end
  endtask

  task automatic send(input logic [63:0] w, output int acc);
    bit r;
    int c;
    s_tdata = w;
    s_tvalid = 1;
    acc = -1;
    for (int k = 0; k < 8 && acc < 0; k++) begin
      r = s_tready;
      c = cyc;
      @(negedge clk);
      if (r) acc = c;
    end
    compared++;
    if (acc < 0) begin
      fails++;
      $display("FAIL send_timeout word=%h: no ready within 8 cycles", w);
    end else model_word(acc, w);
  endtask

  task automatic idle(input int n);
    s_tvalid = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    s_tvalid = 0;
    #1 rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    compared += 5;
    if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b want=0", s_tready); end
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin fails++; $display("FAIL reset_valid got v=%b l=%b want 0 0", m_tvalid, m_tlast); end
    if (m_tdata !== 64'h0) begin fails++; $display("FAIL reset_data got=%h want=0", m_tdata); end
    if (frame_cnt !== 32'h0) begin fails++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
    if (crc_err !== 1'b0) begin fails++; $display("FAIL reset_crc_err got=%b want=0", crc_err); end
    rst_n = 1;
    model_reset();
    #1;
    compared++;
    if (s_tready !== 1'b0) begin fails++; $display("FAIL release_ready_before_edge got=%b want=0", s_tready); end
    @(negedge clk);
    compared += 2;
    if (s_tready !== 1'b1) begin fails++; $display("FAIL release_ready got=%b want=1", s_tready); end
    if (m_tvalid !== 1'b0 || frame_cnt !== 32'h0 || crc_err !== 1'b0) begin
      fails++; $display("FAIL release_idle got v=%b cnt=%0d err=%b want 0 0 0", m_tvalid, frame_cnt, crc_err);
    end
  endtask

  task automatic test_single_frame();
    int c0, f0;
    int acc[FW];
    c0 = cyc;
    f0 = mframes;
    for (int k = 0; k < FW; k++) send(64'(k + 1), acc[k]);
    idle(6);
    for (int k = 0; k < FW; k++) begin
      compared++;
      if (acc[k] !== c0 + k) begin fails++; $display("FAIL single_accept word %0d got cyc=%0d want=%0d", k, acc[k], c0 + k); end
    end
    compared += 3;
    if (tr_r[c0+4] !== 1'b0) begin fails++; $display("FAIL single_bubble_ready got=%b want=0", tr_r[c0+4]); end
    if (tr_f[c0+5] !== 32'(f0)) begin fails++; $display("FAIL single_cnt_before got=%0d want=%0d", tr_f[c0+5], f0); end
    if (tr_f[c0+6] !== 32'(f0 + 1)) begin fails++; $display("FAIL single_cnt_after got=%0d want=%0d", tr_f[c0+6], f0 + 1); end
    for (int c = c0; c < cyc; c++) begin
      compared++;
      if (exp_v[c] ? (tr_v[c] !== 1'b1 || tr_l[c] !== exp_l[c] || tr_d[c] !== exp_d[c]) : tr_v[c] !== 1'b0) begin
        fails++;
        $display("FAIL single_out cyc+%0d got v=%b l=%b d=%h want v=%b l=%b d=%h", c - c0, tr_v[c], tr_l[c], tr_d[c], exp_v[c], exp_l[c], exp_d[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int c0, a;
    c0 = cyc;
    for (int k = 0; k < 2 * FW; k++) begin
      send(64'(k + 1), a);
      compared++;
      if (a !== c0 + k + k / FW) begin fails++; $display("FAIL b2b_accept word %0d got cyc=%0d want=%0d", k, a, c0 + k + k / FW); end
    end
    idle(6);
    for (int c = c0; c < cyc; c++) begin
      compared++;
      if (exp_v[c] ? (tr_v[c] !== 1'b1 || tr_l[c] !== exp_l[c] || tr_d[c] !== exp_d[c]) : tr_v[c] !== 1'b0) begin
        fails++;
        $display("FAIL b2b_out cyc+%0d got v=%b l=%b d=%h want v=%b l=%b d=%h", c - c0, tr_v[c], tr_l[c], tr_d[c], exp_v[c], exp_l[c], exp_d[c]);
      end
    end
  endtask

  task automatic test_gap();
    int c0, a;
    do_reset();
    c0 = cyc;
    send(64'h1, a);
    send(64'h2, a);
    idle(3);
    send(64'h3, a);
    send(64'h4, a);
    idle(6);
    compared++;
    if (tr_l[a+3] !== 1'b1 || tr_d[a+3] !== {MARK, crc_s2}) begin
      fails++; $display("FAIL gap_crc got l=%b d=%h want l=1 d=%h", tr_l[a+3], tr_d[a+3], {MARK, crc_s2});
    end
    for (int c = c0; c < cyc; c++) begin
      compared++;
      if (exp_v[c] ? (tr_v[c] !== 1'b1 || tr_l[c] !== exp_l[c] || tr_d[c] !== exp_d[c]) : tr_v[c] !== 1'b0) begin
        fails++;
        $display("FAIL gap_out cyc+%0d got v=%b l=%b d=%h want v=%b l=%b d=%h", c - c0, tr_v[c], tr_l[c], tr_d[c], exp_v[c], exp_l[c], exp_d[c]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int c0, c1, a;
    c0 = cyc;
    send(64'h1, a);
    send(64'h2, a);
    s_tvalid = 0;
    #1 rst_n = 0;
    #1;
    compared++;
    if (m_tvalid !== 1'b0) begin fails++; $display("FAIL midrst_async_clear got v=%b want=0", m_tvalid); end
    @(negedge clk);
    #1 rst_n = 1;
    model_reset();
    @(negedge clk);
    c1 = cyc;
    for (int k = 0; k < FW; k++) send(64'(k + 1), a);
    idle(6);
    compared++;
    if (tr_r[c0+3] !== 1'b0) begin fails++; $display("FAIL midrst_ready got=%b want=0", tr_r[c0+3]); end
    for (int c = c0; c < c1; c++) begin
      compared++;
      if (tr_l[c] !== 1'b0) begin fails++; $display("FAIL midrst_partial_crc cyc+%0d got tlast=%b want=0", c - c0, tr_l[c]); end
    end
    compared += 2;
    if (tr_d[a+3] !== {MARK, crc_s2}) begin fails++; $display("FAIL midrst_crc got=%h want=%h", tr_d[a+3], {MARK, crc_s2}); end
    if (frame_cnt !== 32'd1) begin fails++; $display("FAIL midrst_frame_cnt got=%0d want=1", frame_cnt); end
    for (int c = c1; c < cyc; c++) begin
      compared++;
      if (exp_v[c] ? (tr_v[c] !== 1'b1 || tr_l[c] !== exp_l[c] || tr_d[c] !== exp_d[c]) : tr_v[c] !== 1'b0) begin
        fails++;
        $display("FAIL midrst_out cyc+%0d got v=%b l=%b d=%h want v=%b l=%b d=%h", c - c1, tr_v[c], tr_l[c], tr_d[c], exp_v[c], exp_l[c], exp_d[c]);
      end
    end
  endtask

  task automatic test_crc_err();
    int c0, a;
    do_reset();
    c0 = cyc;
    send(64'h1, a);
    send(64'h2, a);
    force dut.crc_valid = 1'b0;
    send(64'h3, a);
    release dut.crc_valid;
    send(64'h4, a);
    idle(6);
    compared += 3;
    if (tr_e[c0+2] !== 1'b0) begin fails++; $display("FAIL err_before got=%b want=0", tr_e[c0+2]); end
    if (tr_e[c0+3] !== 1'b1) begin fails++; $display("FAIL err_set got=%b want=1", tr_e[c0+3]); end
    if (crc_err !== 1'b1) begin fails++; $display("FAIL err_sticky got=%b want=1", crc_err); end
    for (int c = c0; c < cyc; c++) begin
      compared++;
      if (exp_v[c] ? (tr_v[c] !== 1'b1 || tr_l[c] !== exp_l[c] || tr_d[c] !== exp_d[c]) : tr_v[c] !== 1'b0) begin
        fails++;
        $display("FAIL err_out cyc+%0d got v=%b l=%b d=%h want v=%b l=%b d=%h", c - c0, tr_v[c], tr_l[c], tr_d[c], exp_v[c], exp_l[c], exp_d[c]);
      end
    end
    do_reset();
    compared++;
    if (crc_err !== 1'b0) begin fails++; $display("FAIL err_cleared got=%b want=0", crc_err); end
  endtask

  task automatic test_random();
    int c0, a;
    do_reset();
    c0 = cyc;
    for (int k = 0; k < 6 * FW; k++) begin
      send({$urandom, $urandom}, a);
      idle($urandom_range(0, 2));
    end
    idle(6);
    compared += 2;
    if (crc_err !== 1'b0) begin fails++; $display("FAIL rand_crc_err got=%b want=0", crc_err); end
    if (frame_cnt !== 32'(mframes)) begin fails++; $display("FAIL rand_frame_cnt got=%0d want=%0d", frame_cnt, mframes); end
    for (int c = c0; c < cyc; c++) begin
      compared++;
      if (exp_v[c] ? (tr_v[c] !== 1'b1 || tr_l[c] !== exp_l[c] || tr_d[c] !== exp_d[c]) : tr_v[c] !== 1'b0) begin
        fails++;
        $display("FAIL rand_out cyc+%0d got v=%b l=%b d=%h want v=%b l=%b d=%h", c - c0, tr_v[c], tr_l[c], tr_d[c], exp_v[c], exp_l[c], exp_d[c]);
      end
    end
  endtask

  initial begin
    crc_s2 = 16'hFFFF;
    for (int k = 1; k <= FW; k++) crc_s2 = ref_crc(crc_s2, 64'(k));
    model_reset();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gap();
    test_reset_mid_frame();
    test_crc_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
